alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch_pkg.sv | 45 ++++
 rtl/alu_dispatch.sv | 130 +++++++++++++
 tb/tb_alu_dispatch.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_dispatch_pkg.sv
// Shared RMT definitions for the ALU dispatcher: action type codes, action field
// positions, dispatch state encoding and the op2 source selection function.
package alu_dispatch_pkg;

    // Action word field positions
    localparam int ACT_TYPE_HI = 24;
    localparam int ACT_TYPE_LO = 21;
    localparam int ACT_IMM_HI  = 15;
    localparam int ACT_IMM_LO  = 0;
    localparam int ACT_ADDR_HI = 4;
    localparam int ACT_ADDR_LO = 0;

    localparam logic [3:0] ACT_ADD   = 4'b0001;
    localparam logic [3:0] ACT_SUB   = 4'b0010;
    localparam logic [3:0] ACT_STORE = 4'b1000;
    localparam logic [3:0] ACT_ADDI  = 4'b1001;
    localparam logic [3:0] ACT_SUBI  = 4'b1010;
    localparam logic [3:0] ACT_LOAD  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dispatch_state_e;

    typedef enum logic [1:0] {
        OP2_SRC_B    = 2'd0,
        OP2_SRC_IMM  = 2'd1,
        OP2_SRC_ADDR = 2'd2
    } op2_src_e;

    // Immediate ops take the 16-bit immediate, RAM ops the 5-bit address,
    // everything else (including unknown codes) the op_b container.
    function automatic op2_src_e op2_select(input logic [3:0] act_type);
        op2_src_e src;
        case (act_type)
            ACT_ADDI, ACT_SUBI:  src = OP2_SRC_IMM;
            ACT_STORE, ACT_LOAD: src = OP2_SRC_ADDR;
            default:             src = OP2_SRC_B;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/alu_dispatch.sv
// One-at-a-time dispatcher from PHV requests to a stateful ALU and back.
// Define ALU_DISPATCH_TIMEOUT_EN to compile in the WAIT timeout (op_c returned, rsp_err=1).
module alu_dispatch #(
    parameter int ACTION_LEN     = 25,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ACTION_LEN-1:0] req_action,
    input  logic [DATA_WIDTH-1:0] req_op_a,
    input  logic [DATA_WIDTH-1:0] req_op_b,
    input  logic [DATA_WIDTH-1:0] req_op_c,
    output logic [ACTION_LEN-1:0] alu_action,
    output logic                  alu_action_valid,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [DATA_WIDTH-1:0] alu_op3,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_result_valid,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);
    import alu_dispatch_pkg::*;

    if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("alu_dispatch: TIMEOUT_CYCLES must be in 4..255");
    end

    dispatch_state_e state, state_nxt;
    logic [3:0]            req_type;
    logic [DATA_WIDTH-1:0] op2_next;
    logic                  accept;
    logic                  result_take;
    logic                  timeout_hit;

    assign req_type    = req_action[ACT_TYPE_HI:ACT_TYPE_LO];
    assign accept      = req_valid && req_ready;
    assign result_take = (state == ST_WAIT) && alu_result_valid;

    always_comb begin
        op2_next = req_op_b;
        case (op2_select(req_type))
            OP2_SRC_IMM:  op2_next = DATA_WIDTH'(req_action[ACT_IMM_HI:ACT_IMM_LO]);
            OP2_SRC_ADDR: op2_next = DATA_WIDTH'(req_action[ACT_ADDR_HI:ACT_ADDR_LO]);
            default:      op2_next = req_op_b;
        endcase
    end

`ifdef ALU_DISPATCH_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Counter is 0 on the first WAIT cycle, so the last allowed cycle sees TIMEOUT_CYCLES-1.
    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state == ST_WAIT)
            wait_cnt <= wait_cnt + 8'd1;
        else
            wait_cnt <= '0;
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (alu_result_valid || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Gating with rst_n keeps handshakes quiet for the whole reset window.
    always_comb begin
        req_ready        = rst_n && (state == ST_IDLE);
        alu_action_valid = rst_n && (state == ST_ISSUE);
        rsp_valid        = rst_n && (state == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_action <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_op3    <= '0;
            rsp_data   <= '0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                alu_action <= req_action;
                alu_op1    <= req_op_a;
                alu_op2    <= op2_next;
                alu_op3    <= req_op_c;
            end
            // A result arriving on the timeout cycle wins over the timeout.
            if (result_take) begin
                rsp_data <= alu_result;
`ifdef ALU_DISPATCH_TIMEOUT_EN
                rsp_err  <= 1'b0;
`endif
            end else if (timeout_hit) begin
                rsp_data <= alu_op3;
`ifdef ALU_DISPATCH_TIMEOUT_EN
                rsp_err  <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed + randomized bench for alu_dispatch; the bench plays the ALU and
// predicts operands and responses from a behavioural reference model.
module tb_alu_dispatch;
    localparam int AL = 25;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk, rst_n;
    logic          req_valid, req_ready;
    logic [AL-1:0] req_action;
    logic [DW-1:0] req_op_a, req_op_b, req_op_c;
    logic [AL-1:0] alu_action;
    logic          alu_action_valid;
    logic [DW-1:0] alu_op1, alu_op2, alu_op3;
    logic [DW-1:0] alu_result;
    logic          alu_result_valid;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    int tests = 0;
    int fails = 0;

    alu_dispatch #(.ACTION_LEN(AL), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_action(req_action),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_op_c(req_op_c),
        .alu_action(alu_action), .alu_action_valid(alu_action_valid),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3),
        .alu_result(alu_result), .alu_result_valid(alu_result_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AL-1:0] mk_act(input logic [3:0] t, input logic [15:0] imm);
        logic [AL-1:0] a;
        a = AL'($urandom);
        a[24:21] = t;
        a[15:0]  = imm;
        return a;
    endfunction

    // Reference op2 rule: immediates and RAM addresses come from the action word.
    function automatic logic [DW-1:0] ref_op2(input logic [AL-1:0] act, input logic [DW-1:0] b);
        logic [3:0] t;
        t = act[24:21];
        if (t == 4'b1001 || t == 4'b1010) return DW'(act[15:0]);
        if (t == 4'b1000 || t == 4'b1011) return DW'(act[4:0]);
        return b;
    endfunction

    // Behavioural ALU: arithmetic for ADD/SUB(I), passthrough of op3 otherwise.
    function automatic logic [DW-1:0] alu_model(input logic [3:0] t, input logic [DW-1:0] o1,
                                                input logic [DW-1:0] o2, input logic [DW-1:0] o3);
        case (t)
            4'b0001, 4'b1001: return o1 + o2;
            4'b0010, 4'b1010: return o1 - o2;
            default:          return o3;
        endcase
    endfunction

    // lat = cycles from alu_action_valid to alu_result_valid; 0 = ALU never answers.
    task automatic run_txn(input string tag, input logic [AL-1:0] act, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] c, input int lat, input int bp);
        logic [DW-1:0] e2, eres, exp_data;
        logic          exp_err;
        int            exp_cyc, cyc;
        bit            got, tmo;
        e2   = ref_op2(act, b);
        eres = alu_model(act[24:21], a, e2, c);
`ifdef ALU_DISPATCH_TIMEOUT_EN
        tmo = (lat == 0 || lat > TO);
`else
        tmo = 1'b0;
`endif
        exp_data = tmo ? c : eres;
        exp_err  = tmo;
        exp_cyc  = tmo ? TO + 2 : lat + 2;

        @(negedge clk);
        check({tag, "/req_ready_idle"}, req_ready, 1);
        req_valid = 1; req_action = act; req_op_a = a; req_op_b = b; req_op_c = c;
        @(negedge clk);
        req_valid = 0; req_action = AL'($urandom); req_op_a = $urandom; req_op_b = $urandom; req_op_c = $urandom;
        cyc = 1; got = 0;
        while (!got && cyc <= 60) begin
            if (cyc == 1) begin
                check({tag, "/issue_valid"}, alu_action_valid, 1);
                check({tag, "/issue_action"}, alu_action, act);
                check({tag, "/issue_op1"}, alu_op1, a);
                check({tag, "/issue_op2"}, alu_op2, e2);
                check({tag, "/issue_op3"}, alu_op3, c);
            end
            if (cyc == 2) check({tag, "/issue_one_cycle"}, alu_action_valid, 0);
            if (rsp_valid) got = 1;
            else begin
                alu_result_valid = (lat != 0 && cyc == lat + 1);
                alu_result       = alu_result_valid ? eres : DW'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        alu_result_valid = 0;
        check({tag, "/rsp_cycle"}, got ? cyc : 0, exp_cyc);
        check({tag, "/rsp_data"}, rsp_data, exp_data);
        check({tag, "/rsp_err"}, rsp_err, exp_err);
        check({tag, "/op3_hold"}, alu_op3, c);
        // Stall the response and throw stray ALU results at it; nothing may move.
        for (int i = 0; i < bp; i++) begin
            alu_result_valid = 1; alu_result = ~exp_data;
            @(negedge clk);
            check({tag, "/bp_valid"}, rsp_valid, 1);
            check({tag, "/bp_data"}, rsp_data, exp_data);
            check({tag, "/bp_err"}, rsp_err, exp_err);
            check({tag, "/bp_req_ready"}, req_ready, 0);
        end
        alu_result_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check({tag, "/done_rsp_valid"}, rsp_valid, 0);
        check({tag, "/done_req_ready"}, req_ready, 1);
    endtask

    initial begin
        logic [3:0] types [7];
        types = '{4'b0001, 4'b0010, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0111};
        rst_n = 0; req_valid = 0; req_action = '0; req_op_a = '0; req_op_b = '0; req_op_c = '0;
        alu_result = '0; alu_result_valid = 0; rsp_ready = 0;

        repeat (3) @(negedge clk);
        check("reset/req_ready", req_ready, 0);
        check("reset/rsp_valid", rsp_valid, 0);
        check("reset/alu_valid", alu_action_valid, 0);
        check("reset/rsp_data", rsp_data, 0);
        check("reset/rsp_err", rsp_err, 0);
        check("reset/alu_op2", alu_op2, 0);
        rst_n = 1;
        @(negedge clk);
        check("release/req_ready", req_ready, 1);

        run_txn("add",   mk_act(4'b0001, 16'h1234), 32'd5, 32'd7, 32'd99, 3, 0);
        run_txn("addi",  mk_act(4'b1001, 16'h0010), 32'd5, 32'hFFFF_FFFF, 32'd1, 3, 0);
        run_txn("store", mk_act(4'b1000, 16'hFFE3), 32'd8, 32'd9, 32'hAA, 3, 0);
        run_txn("bp",    mk_act(4'b0010, 16'h0000), 32'd50, 32'd8, 32'd0, 3, 10);
        run_txn("unk",   mk_act(4'b0111, 16'h00FF), 32'd1, 32'd2, 32'h77, 2, 1);
        run_txn("long",  mk_act(4'b0001, 16'h0000), 32'd3, 32'd4, 32'h55, 20, 0);
`ifdef ALU_DISPATCH_TIMEOUT_EN
        run_txn("tmo",      mk_act(4'b0001, 16'h0000), 32'd3, 32'd4, 32'h55, 0, 2);
        run_txn("tmo_race", mk_act(4'b0001, 16'h0000), 32'd3, 32'd4, 32'h55, TO, 0);
`endif

        // Reset in WAIT, then a stray result after release.
        @(negedge clk);
        req_valid = 1; req_action = mk_act(4'b0001, 16'h0); req_op_a = 32'd1; req_op_b = 32'd2; req_op_c = 32'd3;
        @(negedge clk);
        req_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        check("rstwait/req_ready", req_ready, 0);
        check("rstwait/rsp_valid", rsp_valid, 0);
        check("rstwait/alu_action", alu_action, 0);
        check("rstwait/alu_op1", alu_op1, 0);
        check("rstwait/rsp_data", rsp_data, 0);
        rst_n = 1;
        @(negedge clk);
        check("rstwait/req_ready_after", req_ready, 1);
        alu_result_valid = 1; alu_result = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray/rsp_valid", rsp_valid, 0);
            check("stray/req_ready", req_ready, 1);
        end
        alu_result_valid = 0;
        run_txn("post_rst", mk_act(4'b1010, 16'h0003), 32'd10, 32'd0, 32'd0, 3, 0);

        for (int n = 0; n < 20; n++)
            run_txn("rand", mk_act(types[$urandom_range(6, 0)], 16'($urandom)),
                    $urandom, $urandom, $urandom, $urandom_range(10, 1), $urandom_range(3, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
